// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// countdown_ctrl : start/load/prescaled-decrement sequencer for a 4-bit
//                  loadable down counter, with done pulse and held alarm.
// Revision 1.0
// ============================================================================
module countdown_ctrl #(
  parameter int TICK_DIV  = 4,
  parameter int ALARM_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] load_val,
  input  logic       zero_flag,
  output logic       latch,
  output logic       dec,
  output logic [3:0] IN,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] PRE_TERM = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALM_INIT = AW'(ALARM_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5,
    S_ALARM = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          start_q, start_d;
  logic [3:0]    in_q, in_d;
  logic [AW-1:0] alm_q, alm_d;

  logic start_edge;
  logic tick;

  assign start_edge = start & ~start_q;
  // A pause arriving on the terminal prescaler cycle swallows that tick.
  assign tick       = (state_q == S_RUN) && (pre_q == PRE_TERM) && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      start_q <= 1'b0;
      in_q    <= 4'd0;
      alm_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      start_q <= start_d;
      in_q    <= in_d;
      alm_q   <= alm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    start_d = start;
    in_d    = in_q;
    alm_d   = alm_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_LOAD;
          in_d    = load_val;
        end
      end
      S_LOAD: state_d = S_ARM;
      S_ARM: begin
        pre_d = '0;
        if (zero_flag) state_d = S_DONE;
        else           state_d = S_RUN;
      end
      S_RUN: begin
        if (zero_flag) begin
          state_d = S_DONE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (pre_q == PRE_TERM) begin
          pre_d = '0;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (!pause) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_ALARM;
        alm_d   = ALM_INIT;
      end
      S_ALARM: begin
        if (alm_q <= AW'(1)) begin
          state_d = S_IDLE;
          alm_d   = '0;
        end else begin
          alm_d = alm_q - AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      pre_d   = '0;
      alm_d   = '0;
      in_d    = in_q;
    end
  end

  assign latch = (state_q == S_LOAD);
  assign dec   = tick & ~zero_flag;
  assign IN    = in_q;
  assign busy  = (state_q == S_LOAD) || (state_q == S_ARM) ||
                 (state_q == S_RUN)  || (state_q == S_PAUSE);
  assign done  = (state_q == S_DONE);
  assign alarm = (state_q == S_ALARM);

endmodule
`default_nettype wire
